frame_buffer_ping_pong: RTL and testbench

- Double-buffered grayscale frame store between the camera/preprocessing pixel stream and the VGA display controller.
- Writer side accepts a 160x120 8-bit stream over a valid/ready handshake into one bank. The reader side serves the other bank to the display, addressed by the controller's pixel_x/pixel_y with integer upscaling.
- Bank swap happens only at the start of vertical sync, so the display never tears.
- Single clock domain (pixel clock).

---
 rtl/frame_buffer_ping_pong.sv | 193 +++++++++++++++++++
 tb/tb_frame_buffer_ping_pong.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_ping_pong.sv
// -----------------------------------------------------------------------------
// frame_buffer_ping_pong
//
// Double-buffered 8-bit grayscale frame store that sits between the pixel
// stream from the camera/preprocessing chain and the VGA display controller.
// The writer fills one bank. The reader serves the other bank to the display,
// upscaling by 2**SCALE_SHIFT. The banks swap only on a falling edge of
// vga_vsync, so a displayed frame is never torn.
//
// Ports (single clock domain, clk_25mhz):
//   clk_25mhz       in   pixel clock
//   rst_n           in   asynchronous active-low reset
//   wr_valid        in   write beat valid
//   wr_ready        out  write beat accepted when wr_valid && wr_ready
//   wr_data[7:0]    in   grayscale pixel
//   wr_sof          in   first pixel of a frame (qualified by the handshake)
//   display_enable  in   active-video flag from the display controller
//   pixel_x[15:0]   in   display column
//   pixel_y[15:0]   in   display row
//   vga_vsync       in   active-low vertical sync
//   pixel_data[7:0] out  pixel to the display (one cycle after pixel_x/y)
//   frame_valid     out  sticky: a complete frame has been swapped in
//   frame_count     out  number of swaps taken (wraps)
//   frame_err       out  one-cycle pulse when a frame restarts early
// -----------------------------------------------------------------------------
module frame_buffer_ping_pong #(
  parameter int         IMG_W        = 160,
  parameter int         IMG_H        = 120,
  parameter int         SCALE_SHIFT  = 2,
  parameter logic [7:0] BORDER_VALUE = 8'h00
) (
  input  logic        clk_25mhz,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_data,
  input  logic        wr_sof,
  input  logic        display_enable,
  input  logic [15:0] pixel_x,
  input  logic [15:0] pixel_y,
  input  logic        vga_vsync,
  output logic [7:0]  pixel_data,
  output logic        frame_valid,
  output logic [15:0] frame_count,
  output logic        frame_err
);

  localparam int FRAME_PIXELS = IMG_W * IMG_H;
  localparam int ADDR_W       = $clog2(2 * FRAME_PIXELS);
  localparam int PIX_W        = $clog2(FRAME_PIXELS);

  localparam logic [PIX_W-1:0]  LAST_PIX   = PIX_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(FRAME_PIXELS);
  localparam logic [ADDR_W-1:0] IMG_W_A    = ADDR_W'(IMG_W);
  localparam logic [15:0]       IMG_W_16   = 16'(IMG_W);
  localparam logic [15:0]       IMG_H_16   = 16'(IMG_H);

  // Write FSM encoding
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITE     = 2'd1;
  localparam logic [1:0] ST_WAIT_SWAP = 2'd2;

  logic [1:0]       state;
  logic [PIX_W-1:0] wr_addr;
  logic             wr_bank;
  logic             rd_bank;
  logic             pending;
  logic             out_of_reset;
  logic             vsync_q;

  logic             accept;
  logic             restart;
  logic             last_beat;
  logic             swap_event;
  logic             mem_we;
  logic [PIX_W-1:0] mem_off;
  logic [ADDR_W-1:0] mem_waddr;

  logic [15:0]       src_x;
  logic [15:0]       src_y;
  logic              in_image;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        mem_q;
  logic              border_q;

  logic [7:0] mem [2 * FRAME_PIXELS];

  assign wr_ready   = (state != ST_WAIT_SWAP) && out_of_reset;
  assign accept     = wr_valid && wr_ready;
  assign swap_event = vsync_q && !vga_vsync;

  // A sof in the middle of a frame abandons the partial frame and restarts it.
  assign restart   = accept && (state == ST_WRITE) && wr_sof && (wr_addr != '0);
  assign last_beat = accept && (state == ST_WRITE) && !restart && (wr_addr == LAST_PIX);

  // NOTE: every output of a combinational block gets a default first so that
  // no path through the case statement leaves it unassigned (no latch).
  always_comb begin
    mem_we  = 1'b0;
    mem_off = wr_addr;
    if (accept) begin
      case (state)
        ST_IDLE: begin
          mem_we  = wr_sof;
          mem_off = '0;
        end
        ST_WRITE: begin
          mem_we = 1'b1;
          if (restart) mem_off = '0;
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  assign mem_waddr = (wr_bank ? BANK1_BASE : '0) + ADDR_W'(mem_off);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      wr_addr      <= '0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b1;
      pending      <= 1'b0;
      out_of_reset <= 1'b0;
      vsync_q      <= 1'b1;
      frame_valid  <= 1'b0;
      frame_count  <= '0;
      frame_err    <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      vsync_q      <= vga_vsync;
      frame_err    <= restart;
      if (swap_event && pending) begin
        // Hand the finished bank to the reader; the writer gets the old one.
        rd_bank     <= wr_bank;
        wr_bank     <= ~wr_bank;
        pending     <= 1'b0;
        state       <= ST_IDLE;
        wr_addr     <= '0;
        frame_valid <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept && wr_sof) begin
              state   <= ST_WRITE;
              wr_addr <= PIX_W'(1);
            end
          end
          ST_WRITE: begin
            if (restart) begin
              wr_addr <= PIX_W'(1);
            end else if (last_beat) begin
              state   <= ST_WAIT_SWAP;
              pending <= 1'b1;
            end else if (accept) begin
              wr_addr <= wr_addr + PIX_W'(1);
            end
          end
          ST_WAIT_SWAP: state <= ST_WAIT_SWAP;
          default:      state <= ST_IDLE;
        endcase
      end
    end
  end

  // Read side: integer upscaling by dropping the low coordinate bits.
  assign src_x    = pixel_x >> SCALE_SHIFT;
  assign src_y    = pixel_y >> SCALE_SHIFT;
  assign in_image = display_enable && frame_valid && (src_x < IMG_W_16) && (src_y < IMG_H_16);
  assign rd_addr  = (rd_bank ? BANK1_BASE : '0) + ADDR_W'(src_y) * IMG_W_A + ADDR_W'(src_x);

  // NOTE: the storage array has no reset; clearing it would cost a full
  // frame of cycles and prevent RAM inference. Stale contents are masked by
  // frame_valid until a complete frame has been swapped in.
  always_ff @(posedge clk_25mhz) begin
    if (mem_we) mem[mem_waddr] <= wr_data;
    mem_q <= mem[rd_addr];
  end

  // The border decision is registered alongside the RAM read so both line up
  // on the same cycle; its reset value forces BORDER_VALUE out of reset.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) border_q <= 1'b1;
    else        border_q <= !in_image;
  end

  assign pixel_data = border_q ? BORDER_VALUE : mem_q;

endmodule

// File: tb/tb_frame_buffer_ping_pong.sv
// -----------------------------------------------------------------------------
// tb_frame_buffer_ping_pong
//
// Directed bench for frame_buffer_ping_pong with its default parameters
// (160x120, upscale x4, border 0x00). Inputs change 1 time unit after a
// rising edge; outputs are sampled at that same point, i.e. they show the
// result of the preceding edge.
// -----------------------------------------------------------------------------
module tb_frame_buffer_ping_pong;

  localparam int FRAME = 19200;

  logic        clk_25mhz = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic        wr_sof;
  logic        display_enable;
  logic [15:0] pixel_x;
  logic [15:0] pixel_y;
  logic        vga_vsync;
  logic [7:0]  pixel_data;
  logic        frame_valid;
  logic [15:0] frame_count;
  logic        frame_err;

  int errors = 0;
  int checks = 0;
  int stalls = 0;

  frame_buffer_ping_pong dut (
    .clk_25mhz      (clk_25mhz),
    .rst_n          (rst_n),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .wr_sof         (wr_sof),
    .display_enable (display_enable),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .vga_vsync      (vga_vsync),
    .pixel_data     (pixel_data),
    .frame_valid    (frame_valid),
    .frame_count    (frame_count),
    .frame_err      (frame_err)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_25mhz);
      #1;
    end
  endtask

  // One write beat; a beat the DUT would not accept is counted as a stall.
  task automatic send_beat(input logic [7:0] d, input logic s);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_sof   = s;
    if (wr_ready !== 1'b1) stalls++;
    tick(1);
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
  endtask

  // Present a display coordinate and sample the pixel one cycle later.
  task automatic read_px(input string tag, input int x, input int y, input logic [7:0] expected);
    pixel_x = 16'(x);
    pixel_y = 16'(y);
    tick(1);
    check(tag, {24'h0, pixel_data}, {24'h0, expected});
  endtask

  // Falling vsync edge: one cycle low after at least one cycle high.
  task automatic vsync_fall();
    vga_vsync = 1'b1;
    tick(2);
    vga_vsync = 1'b0;
    tick(1);
  endtask

  initial begin
    rst_n          = 1'b0;
    wr_valid       = 1'b0;
    wr_data        = 8'h00;
    wr_sof         = 1'b0;
    display_enable = 1'b1;
    pixel_x        = 16'd0;
    pixel_y        = 16'd0;
    vga_vsync      = 1'b1;

    // ---- reset state ----
    tick(3);
    check("rst_pixel", {24'h0, pixel_data}, 32'h00);
    check("rst_valid", {31'h0, frame_valid}, 32'h0);
    check("rst_count", {16'h0, frame_count}, 32'h0);
    check("rst_ready", {31'h0, wr_ready}, 32'h0);
    rst_n = 1'b1;
    #1;
    check("ready_before_first_clk", {31'h0, wr_ready}, 32'h0);
    tick(1);
    check("ready_after_first_clk", {31'h0, wr_ready}, 32'h1);
    read_px("pix_before_frame", 0, 0, 8'h00);

    // ---- frame A: data = address[7:0] ----
    stalls = 0;
    for (int i = 0; i < FRAME; i++) send_beat(8'(i), i == 0);
    check("a_stalls", stalls, 0);
    check("a_ready_after_last", {31'h0, wr_ready}, 32'h0);
    check("a_valid_before_swap", {31'h0, frame_valid}, 32'h0);
    vsync_fall();
    check("a_valid", {31'h0, frame_valid}, 32'h1);
    check("a_count", {16'h0, frame_count}, 32'd1);
    check("a_ready_after_swap", {31'h0, wr_ready}, 32'h1);
    vga_vsync = 1'b1;
    read_px("a_px_8_0", 8, 0, 8'h02);
    read_px("a_px_4_4", 4, 4, 8'hA1);
    read_px("a_px_700_0", 700, 0, 8'h00);
    read_px("a_px_last", 639, 479, 8'hFF);
    read_px("a_px_row480", 0, 480, 8'h00);
    display_enable = 1'b0;
    read_px("a_px_blanked", 4, 4, 8'h00);
    display_enable = 1'b1;

    // ---- beats without sof are discarded ----
    stalls = 0;
    for (int i = 0; i < 10; i++) send_beat(8'hEE, 1'b0);
    check("discard_stalls", stalls, 0);

    // ---- frame B (all 0x55) while frame A is displayed ----
    for (int i = 0; i < FRAME; i++) send_beat(8'h55, i == 0);
    check("b_stalls", stalls, 0);
    check("b_ready_after_last", {31'h0, wr_ready}, 32'h0);
    read_px("b_still_a", 4, 4, 8'hA1);
    check("b_count_before_swap", {16'h0, frame_count}, 32'd1);
    vsync_fall();
    check("b_count", {16'h0, frame_count}, 32'd2);
    vga_vsync = 1'b1;
    read_px("b_px_4_4", 4, 4, 8'h55);
    read_px("b_px_0_0", 0, 0, 8'h55);
    read_px("b_px_last", 639, 479, 8'h55);

    // ---- frame C: restart at beat 500, idle vsync edge while writing ----
    stalls = 0;
    for (int i = 0; i < 500; i++) send_beat(8'h11, i == 0);
    check("c_err_quiet", {31'h0, frame_err}, 32'h0);
    send_beat(8'h77, 1'b1);
    check("c_err_pulse", {31'h0, frame_err}, 32'h1);
    send_beat(8'h33, 1'b0);
    check("c_err_one_cycle", {31'h0, frame_err}, 32'h0);
    for (int i = 1; i < FRAME - 1; i++) begin
      if (i == 1000) vga_vsync = 1'b0;
      if (i == 1003) vga_vsync = 1'b1;
      send_beat(8'h33, 1'b0);
    end
    check("c_stalls", stalls, 0);
    check("c_count_no_pending", {16'h0, frame_count}, 32'd2);
    check("c_ready_after_last", {31'h0, wr_ready}, 32'h0);
    vsync_fall();
    check("c_count", {16'h0, frame_count}, 32'd3);
    vga_vsync = 1'b1;
    read_px("c_px_restart_at_0", 0, 0, 8'h77);
    read_px("c_px_4_0", 4, 0, 8'h33);

    // ---- frame D: last beat coincides with the vsync edge ----
    stalls = 0;
    tick(2);
    for (int i = 0; i < FRAME; i++) begin
      if (i == FRAME - 1) vga_vsync = 1'b0;
      send_beat(8'h99, i == 0);
    end
    check("d_stalls", stalls, 0);
    check("d_same_cycle_no_swap", {16'h0, frame_count}, 32'd3);
    check("d_pending_ready", {31'h0, wr_ready}, 32'h0);
    read_px("d_still_c", 0, 0, 8'h77);
    vsync_fall();
    check("d_count", {16'h0, frame_count}, 32'd4);
    vga_vsync = 1'b1;
    read_px("d_px_0_0", 0, 0, 8'h99);

    // ---- reset in the middle of a write ----
    for (int i = 0; i < 100; i++) send_beat(8'h22, i == 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, frame_valid}, 32'h0);
    check("mid_rst_pixel", {24'h0, pixel_data}, 32'h00);
    check("mid_rst_count", {16'h0, frame_count}, 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("post_rst_ready", {31'h0, wr_ready}, 32'h1);
    vsync_fall();
    check("post_rst_no_swap_count", {16'h0, frame_count}, 32'h0);
    check("post_rst_no_swap_valid", {31'h0, frame_valid}, 32'h0);
    vga_vsync = 1'b1;
    read_px("post_rst_pixel", 0, 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
